// File: rtl/alu_display_pkg.sv
// Shared types and constants for the ALU demo-board seven-segment scanner.
package alu_display_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SUB = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV_A,
    S_CONV_B,
    S_COMMIT
  } state_t;

  // One frame slot: code is a hex nibble or a BCD digit, dp_n is active-low.
  typedef struct packed {
    logic       blank;
    logic       dp_n;
    logic [3:0] code;
  } digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic       SEG_DP    = 1'b0;

  // Decimal digits needed to show the largest unsigned w-bit value.
  function automatic int dec_digits(input int w);
    longint unsigned v;
    int              n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    while (v != 0) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex7seg (
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_code)
      4'h0:    o_seg = 7'b1000000;
      4'h1:    o_seg = 7'b1111001;
      4'h2:    o_seg = 7'b0100100;
      4'h3:    o_seg = 7'b0110000;
      4'h4:    o_seg = 7'b0011001;
      4'h5:    o_seg = 7'b0010010;
      4'h6:    o_seg = 7'b0000010;
      4'h7:    o_seg = 7'b1111000;
      4'h8:    o_seg = 7'b0000000;
      4'h9:    o_seg = 7'b0010000;
      4'hA:    o_seg = 7'b0001000;
      4'hB:    o_seg = 7'b0000011;
      4'hC:    o_seg = 7'b1000110;
      4'hD:    o_seg = 7'b0100001;
      4'hE:    o_seg = 7'b0000110;
      default: o_seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/alu_display_scan.sv
// Snapshots ALU operands/result, renders them in hex or decimal (sequential
// double-dabble) into a double-buffered frame, and scans it over N_DIGITS anodes.
module alu_display_scan
  import alu_display_pkg::*;
#(
  parameter int W           = 8,
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          op,
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  input  logic [W-1:0]        res,
  input  logic                load,
  input  logic                dec_mode,
  output logic                busy,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg,
  output logic                dp
);

  localparam int DD   = dec_digits(W);
  localparam int HALF = N_DIGITS / 2;
  localparam int CW   = $clog2(W);
  localparam int IW   = $clog2(N_DIGITS);
  localparam int PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t r_state, w_state_nxt;

  logic [2:0]      r_op;
  logic [W-1:0]    r_a, r_b, r_res;
  logic            r_dec;
  logic [W-1:0]    r_bin;
  logic [4*DD-1:0] r_bcd, r_dec_a, w_adj, w_bcd_nxt;
  logic [CW-1:0]   r_cnt;
  logic            w_last, w_res_mode, w_in_res_mode, w_busy;

  logic [4*HALF-1:0] w_lo_nib, w_hi_nib;
  logic [HALF-1:0]   w_lo_blank, w_hi_blank;
  digit_t            w_frame [N_DIGITS];
  digit_t            r_frame [N_DIGITS];
  digit_t            w_cur;

  logic [PW-1:0]       r_presc;
  logic [IW-1:0]       r_idx;
  logic [6:0]          w_hex_seg;
  logic [N_DIGITS-1:0] r_an;
  logic [6:0]          r_seg;
  logic                r_dp;

  assign w_in_res_mode = (op == OP_ADD) || (op == OP_SUB);
  assign w_res_mode    = (r_op == OP_ADD) || (r_op == OP_SUB);
  assign w_last        = (r_cnt == CW'(W - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first keeps every path driven, so no latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (load)   w_state_nxt = dec_mode ? S_CONV_A : S_COMMIT;
      S_CONV_A: if (w_last) w_state_nxt = w_res_mode ? S_COMMIT : S_CONV_B;
      S_CONV_B: if (w_last) w_state_nxt = S_COMMIT;
      S_COMMIT:             w_state_nxt = S_IDLE;
      default:              w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next bit.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DD; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_nxt = (w_adj << 1) | {{(4*DD-1){1'b0}}, r_bin[W-1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_dec   <= 1'b0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_dec_a <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (load) begin
          r_op  <= op;
          r_a   <= a;
          r_b   <= b;
          r_res <= res;
          r_dec <= dec_mode;
          r_bin <= w_in_res_mode ? res : a;
          r_bcd <= '0;
          r_cnt <= '0;
        end
        S_CONV_A, S_CONV_B: begin
          r_bcd <= w_bcd_nxt;
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + CW'(1);
          // First conversion parks in r_dec_a; the converter is then reloaded with b.
          if (r_state == S_CONV_A && w_last) begin
            r_dec_a <= w_bcd_nxt;
            r_bin   <= r_b;
            r_bcd   <= '0;
            r_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic [HALF-1:0] lead_blank(input logic [4*HALF-1:0] nib);
    logic            seen;
    logic [HALF-1:0] blank;
    seen = 1'b0;
    for (int i = HALF - 1; i >= 0; i--) begin
      seen     = seen | (nib[4*i +: 4] != 4'd0);
      blank[i] = ~seen & (i != 0);
    end
    return blank;
  endfunction

  always_comb begin
    w_lo_nib = '0;
    w_hi_nib = '0;
    if (r_dec) begin
      w_hi_nib[4*DD-1:0] = r_dec_a;
      w_lo_nib[4*DD-1:0] = w_res_mode ? r_dec_a : r_bcd;
    end else begin
      w_hi_nib[W-1:0] = r_a;
      w_lo_nib[W-1:0] = w_res_mode ? r_res : r_b;
    end
  end

  assign w_lo_blank = lead_blank(w_lo_nib);
  assign w_hi_blank = lead_blank(w_hi_nib);

  always_comb begin
    for (int i = 0; i < HALF; i++) begin
      w_frame[i].blank = w_lo_blank[i];
      w_frame[i].dp_n  = ~SEG_DP;
      w_frame[i].code  = w_lo_nib[4*i +: 4];
      w_frame[HALF+i].blank = w_res_mode | w_hi_blank[i];
      w_frame[HALF+i].dp_n  = (!w_res_mode && i == 0) ? SEG_DP : ~SEG_DP;
      w_frame[HALF+i].code  = w_hi_nib[4*i +: 4];
    end
  end

  // NOTE: the frame is a small register file, reset explicitly because a blank
  // display after reset is an observable requirement, not a simulation nicety.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_DIGITS; i++) r_frame[i] <= '{blank: 1'b1, dp_n: 1'b1, code: 4'd0};
    end else if (r_state == S_COMMIT) begin
      for (int i = 0; i < N_DIGITS; i++) r_frame[i] <= w_frame[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PW'(REFRESH_DIV - 1)) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IW'(N_DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign w_cur = r_frame[r_idx];

  hex7seg u_hex7seg (
    .i_code (w_cur.code),
    .o_seg  (w_hex_seg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else if (w_cur.blank) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(N_DIGITS'(1) << r_idx);
      r_seg <= w_hex_seg;
      r_dp  <= w_cur.dp_n;
    end
  end

  assign busy = w_busy;
  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = r_dp;

endmodule

// File: tb/tb_alu_display_scan.sv
// Scoreboard bench: each load pushes an expected frame; a monitor measures the
// busy window and one full scan after every commit and compares.
module tb_alu_display_scan;

  typedef struct packed {
    logic [7:0]  busy;
    logic [7:0]  lit;
    logic [55:0] segs;
    logic [7:0]  dps;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [2:0] op = '0;
  logic [7:0] a = '0, b = '0, res = '0;
  logic       load = 1'b0, dec_mode = 1'b0;
  logic       busy1, busy2, dp1, dp2;
  logic [7:0] an1, an2;
  logic [6:0] seg1, seg2;

  int   n_vec = 0, n_miss = 0, n_push = 0, n_done = 0;
  exp_t exp_q[$];

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  alu_display_scan #(.W(8), .N_DIGITS(8), .REFRESH_DIV(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .op(op), .a(a), .b(b), .res(res), .load(load),
    .dec_mode(dec_mode), .busy(busy1), .an(an1), .seg(seg1), .dp(dp1)
  );

  alu_display_scan #(.W(8), .N_DIGITS(8), .REFRESH_DIV(2)) u_dut_fast (
    .clk(clk), .reset_n(reset_n), .op(op), .a(a), .b(b), .res(res), .load(load),
    .dec_mode(dec_mode), .busy(busy2), .an(an2), .seg(seg2), .dp(dp2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk_exp(input int busy_c, input logic [7:0] lit,
                                  input logic [31:0] codes, input logic [7:0] dps);
    exp_t e;
    e.busy = 8'(busy_c);
    e.lit  = lit;
    e.dps  = dps;
    for (int d = 0; d < 8; d++) e.segs[d*7 +: 7] = lit[d] ? seg_tab[codes[d*4 +: 4]] : 7'h7F;
    return e;
  endfunction

  // Watches 32 cycles (one full scan of the REFRESH_DIV=4 instance).
  task automatic scan_frame(output logic [7:0] lit, output logic [55:0] segs,
                            output logic [7:0] dps, output int bad);
    int cnt [8];
    int hit;
    lit = '0; segs = '1; dps = '0; bad = 0;
    for (int d = 0; d < 8; d++) cnt[d] = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (an1 == 8'hFF) begin
        if (seg1 !== 7'h7F || dp1 !== 1'b1) bad++;
      end else begin
        hit = -1;
        for (int d = 0; d < 8; d++) if (an1 == ~(8'h01 << d)) hit = d;
        if (hit < 0) bad++;
        else begin
          if (lit[hit] && segs[hit*7 +: 7] !== seg1) bad++;
          cnt[hit]++;
          lit[hit] = 1'b1;
          segs[hit*7 +: 7] = seg1;
          dps[hit] = ~dp1;
        end
      end
    end
    for (int d = 0; d < 8; d++) if (lit[d] && cnt[d] != 4) bad++;
  endtask

  task automatic do_load(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] vr, input logic dm);
    @(negedge clk);
    op = o; a = va; b = vb; res = vr; dec_mode = dm; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic push(input exp_t e);
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (n_done != n_push && k < 500) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done"}, n_done, n_push);
  endtask

  initial begin : monitor
    int          busy_cnt;
    logic        busy_q;
    exp_t        e;
    logic [7:0]  lit, dps;
    logic [55:0] segs;
    int          bad;
    busy_cnt = 0;
    busy_q   = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_cnt = 0;
        busy_q   = 1'b0;
      end else if (busy1) begin
        busy_cnt++;
        busy_q = 1'b1;
      end else if (busy_q) begin
        busy_q = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_commit", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("busy_cycles", busy_cnt, e.busy);
          scan_frame(lit, segs, dps, bad);
          check("frame_lit", lit, e.lit);
          check("frame_segs", segs, e.segs);
          check("frame_dp", dps, e.dps);
          check("scan_timing", bad, 0);
          n_done++;
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t        old_frame;
    logic [7:0]  lit, dps, prev_an;
    logic [55:0] segs;
    int          bad, k, t4, t5, t6, t0b;
    logic        found;

    #1 reset_n = 1'b0;
    #2;
    check("rst_an", an1, 8'hFF);
    check("rst_seg", seg1, 7'h7F);
    check("rst_dp", dp1, 1'b1);
    check("rst_busy", busy1, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Hex result mode: 0x3C -> "3" on digit 1, "C" on digit 0.
    old_frame = mk_exp(1, 8'h03, 32'h0000_003C, 8'h00);
    push(old_frame);
    do_load(3'b001, 8'h00, 8'h00, 8'h3C, 1'b0);
    wait_done("hex_res");

    // Decimal two-operand 255 / 7, with an ignored load and input changes mid-conversion.
    push(mk_exp(17, 8'b0111_0001, 32'h0255_0007, 8'h10));
    do_load(3'b010, 8'd255, 8'd7, 8'h00, 1'b1);
    bad = 0;
    k = 0;
    while (busy1 && k < 40) begin
      if (an1 != 8'hFF) begin
        for (int d = 0; d < 8; d++)
          if (an1 == ~(8'h01 << d) && (!old_frame.lit[d] || seg1 !== old_frame.segs[d*7 +: 7])) bad++;
      end
      if (k == 4) begin
        a = 8'h12; b = 8'h34; res = 8'h99; op = 3'b001; dec_mode = 1'b0; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      k++;
      @(negedge clk);
    end
    load = 1'b0;
    check("dbuf_old_frame", bad, 0);
    check("dbuf_busy_len", k, 17);
    wait_done("dec_two_op");

    // Wrap-around on the REFRESH_DIV=2 instance: digits 0,4,5,6 lit, period 16.
    prev_an = an2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an2 == 8'hFE && prev_an != 8'hFE) found = 1'b1;
      prev_an = an2;
    end
    check("wrap_align", found, 1'b1);
    t4 = -1; t5 = -1; t6 = -1; t0b = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (an2 == 8'hEF && t4 < 0) t4 = i;
      if (an2 == 8'hDF && t5 < 0) t5 = i;
      if (an2 == 8'hBF && t6 < 0) t6 = i;
      if (an2 == 8'hFE && prev_an != 8'hFE && t0b < 0) t0b = i;
      prev_an = an2;
    end
    check("wrap_digit4", t4, 8);
    check("wrap_digit5", t5, 10);
    check("wrap_digit6", t6, 12);
    check("wrap_period", t0b, 16);

    // Decimal result mode: 200 keeps its inner zeros.
    push(mk_exp(9, 8'b0000_0111, 32'h0000_0200, 8'h00));
    do_load(3'b100, 8'h11, 8'h22, 8'd200, 1'b1);
    wait_done("dec_res");

    // Hex two-operand: A5 / 0F, leading zero of b blanked.
    push(mk_exp(1, 8'b0011_0001, 32'h00A5_000F, 8'h10));
    do_load(3'b011, 8'hA5, 8'h0F, 8'h00, 1'b0);
    wait_done("hex_two_op");

    // Reset mid-scan, then the first frame after release is blank.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_scan_an", an1, 8'hFF);
    check("rst_scan_seg", seg1, 7'h7F);
    check("rst_scan_dp", dp1, 1'b1);
    check("rst_scan_busy", busy1, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    scan_frame(lit, segs, dps, bad);
    check("post_rst_lit", lit, 8'h00);
    check("post_rst_scan", bad, 0);

    // Default op with zero operands: digits 4 and 0 show "0".
    push(mk_exp(1, 8'h11, 32'h0000_0000, 8'h10));
    do_load(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    wait_done("zero");

    // Reset during CONV_A: conversion abandoned, frame blank.
    do_load(3'b010, 8'd99, 8'd42, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    check("conv_busy", busy1, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_conv_an", an1, 8'hFF);
    check("rst_conv_seg", seg1, 7'h7F);
    check("rst_conv_dp", dp1, 1'b1);
    check("rst_conv_busy", busy1, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    scan_frame(lit, segs, dps, bad);
    check("post_conv_rst_lit", lit, 8'h00);
    check("post_conv_rst_busy", busy1, 1'b0);
    check("no_pending_frames", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
